test_data_verify: RTL and testbench

Self-checking receiver for the synthetic test-data stream. Internally regenerates the expected line sequence from a 64-bit seed, compares every received line against it, and reports mismatch count and first-failure location. Sits at the receive end of memory/host loopback tests, complementing the line generator and hash checker where exact per-line pass/fail is needed instead of a software-compared hash.

---
 rtl/test_data_pkg.sv | 38 +++
 rtl/test_data_expect.sv | 54 +++++
 rtl/test_data_verify.sv | 135 +++++++++++++
 tb/tb_test_data_verify.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/test_data_pkg.sv
// Shared constants and word-update helpers for the synthetic test-data line sequence.
// Used by the verifier and by any generator that must produce the same lines.
package test_data_pkg;

    // 512-bit seed pattern, most significant word first; word k of a line uses INIT[(64k mod 512) +: 64]
    localparam logic [511:0] INIT = {
        64'h8644554624594bbf, 64'hb173761f0b5a083b,
        64'h76655f3e9ba84438, 64'hafcc6ba3db67f2b3,
        64'h33b23fb3ab3c4277, 64'h8519a51b2767a2fa,
        64'h54de0dc97b564cbf, 64'h860761722b164a00
    };

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } t_state;

    function automatic logic [63:0] rotl(input logic [63:0] v, input logic [5:0] r);
        logic [127:0] dbl;
        dbl = {v, v} << r;
        return dbl[127:64];
    endfunction

    function automatic logic [63:0] init_word(input logic [63:0] seed, input int unsigned k);
        logic [5:0] r;
        r = k[5:0];
        return INIT[(k % 8) * 64 +: 64] ^ rotl(seed, r);
    endfunction

    function automatic logic [63:0] next_word(input logic [63:0] w, input logic [63:0] seed,
                                              input int unsigned k);
        logic [5:0] r;
        r = k[5:0];
        return {w[55:0], w[63:56]} ^ rotl(seed, r);
    endfunction

endpackage

// File: rtl/test_data_expect.sv
// Expected-line generator: loads the initial line from a seed and steps to the next line on advance.
// The seed is held internally so later lines keep using the value captured at load.
module test_data_expect
    import test_data_pkg::*;
#(
    parameter int DATA_WIDTH = 512
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  load,
    input  logic                  advance,
    input  logic [63:0]           seed,
    output logic [DATA_WIDTH-1:0] expected
);
    localparam int WORDS = DATA_WIDTH / 64;

    logic [63:0] seed_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            seed_q <= '0;
        end else if (load) begin
            seed_q <= seed;
        end
    end

    generate
        for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
            logic [63:0] word_q;
            logic [63:0] word_d;

            // load and advance never coincide: load only happens outside a run
            always_comb begin
                word_d = word_q;
                if (load) begin
                    word_d = init_word(seed, gi);
                end else if (advance) begin
                    word_d = next_word(word_q, seed_q, gi);
                end
            end

            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    word_q <= '0;
                end else begin
                    word_q <= word_d;
                end
            end

            assign expected[gi*64 +: 64] = word_q;
        end
    endgenerate

endmodule

// File: rtl/test_data_verify.sv
// Self-checking receiver: compares each accepted line against the regenerated sequence.
// Define TEST_DATA_VERIFY_MISMATCH_MASK_EN to add first_err_mask (per-word mismatch map of the first bad line).
module test_data_verify
    import test_data_pkg::*;
#(
    parameter int DATA_WIDTH = 512,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [63:0]           seed,
    input  logic [CNT_WIDTH-1:0]  num_lines,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    input  logic [DATA_WIDTH-1:0] rx_data,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_WIDTH-1:0]  lines_checked,
    output logic [CNT_WIDTH-1:0]  error_cnt,
    output logic                  first_err_valid,
    output logic [CNT_WIDTH-1:0]  first_err_idx
`ifdef TEST_DATA_VERIFY_MISMATCH_MASK_EN
    ,
    output logic [DATA_WIDTH/64-1:0] first_err_mask
`endif
);
    localparam int WORDS = DATA_WIDTH / 64;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    t_state                state_q;
    logic [CNT_WIDTH-1:0]  num_lines_q;
    logic [CNT_WIDTH-1:0]  lines_checked_q;
    logic [CNT_WIDTH-1:0]  error_cnt_q;
    logic [CNT_WIDTH-1:0]  error_cnt_d;
    logic [CNT_WIDTH-1:0]  first_err_idx_q;
    logic                  first_err_valid_q;
    logic                  busy_q;
    logic                  done_q;
    logic [DATA_WIDTH-1:0] expected;
    logic [WORDS-1:0]      word_miss;
    logic                  line_miss;
    logic                  accept;
    logic                  load;

    // The compare lands in the same edge as the accept, so no line is ever in flight.
    assign rx_ready    = (state_q == ST_RUN) && (lines_checked_q < num_lines_q);
    assign accept      = rx_valid && rx_ready;
    assign load        = start && (state_q != ST_RUN);
    assign line_miss   = |word_miss;
    assign error_cnt_d = (&error_cnt_q) ? error_cnt_q : error_cnt_q + CNT_ONE;

    generate
        for (genvar gi = 0; gi < WORDS; gi++) begin : g_cmp
            assign word_miss[gi] = rx_data[gi*64 +: 64] != expected[gi*64 +: 64];
        end
    endgenerate

    test_data_expect #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_expect (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (load),
        .advance (accept),
        .seed    (seed),
        .expected(expected)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q           <= ST_IDLE;
            num_lines_q       <= '0;
            lines_checked_q   <= '0;
            error_cnt_q       <= '0;
            first_err_valid_q <= 1'b0;
            first_err_idx_q   <= '0;
            busy_q            <= 1'b0;
            done_q            <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (lines_checked_q == num_lines_q) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (accept) begin
                        lines_checked_q <= lines_checked_q + CNT_ONE;
                        if (line_miss) begin
                            error_cnt_q <= error_cnt_d;
                            if (!first_err_valid_q) begin
                                first_err_valid_q <= 1'b1;
                                first_err_idx_q   <= lines_checked_q;
                            end
                        end
                    end
                end
                default: begin
                    if (start) begin
                        state_q           <= ST_RUN;
                        num_lines_q       <= num_lines;
                        lines_checked_q   <= '0;
                        error_cnt_q       <= '0;
                        first_err_valid_q <= 1'b0;
                        first_err_idx_q   <= '0;
                        busy_q            <= 1'b1;
                        done_q            <= 1'b0;
                    end
                end
            endcase
        end
    end

`ifdef TEST_DATA_VERIFY_MISMATCH_MASK_EN
    logic [WORDS-1:0] first_err_mask_q;

    always_ff @(posedge clk) begin
        if (!reset_n || load) begin
            first_err_mask_q <= '0;
        end else if (accept && line_miss && !first_err_valid_q) begin
            first_err_mask_q <= word_miss;
        end
    end

    assign first_err_mask = first_err_mask_q;
`endif

    assign busy            = busy_q;
    assign done            = done_q;
    assign lines_checked   = lines_checked_q;
    assign error_cnt       = error_cnt_q;
    assign first_err_valid = first_err_valid_q;
    assign first_err_idx   = first_err_idx_q;

endmodule

// File: tb/tb_test_data_verify.sv
// Directed bench for test_data_verify: closed-form line model, per-cycle output compare, literal pins.
`timescale 1ns/1ps
module tb_test_data_verify;
    localparam int DW    = 512;
    localparam int CW    = 32;
    localparam int WORDS = DW / 64;

    localparam logic [63:0] INIT_W [8] = '{
        64'h860761722b164a00, 64'h54de0dc97b564cbf, 64'h8519a51b2767a2fa, 64'h33b23fb3ab3c4277,
        64'hafcc6ba3db67f2b3, 64'h76655f3e9ba84438, 64'hb173761f0b5a083b, 64'h8644554624594bbf
    };

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [63:0]   seed = '0;
    logic [CW-1:0] num_lines = '0;
    logic          rx_valid = 1'b0;
    logic [DW-1:0] rx_data = '0;
    logic          rx_ready;
    logic          busy;
    logic          done;
    logic [CW-1:0] lines_checked;
    logic [CW-1:0] error_cnt;
    logic          first_err_valid;
    logic [CW-1:0] first_err_idx;
`ifdef TEST_DATA_VERIFY_MISMATCH_MASK_EN
    logic [WORDS-1:0] first_err_mask;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    test_data_verify #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .seed           (seed),
        .num_lines      (num_lines),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
        .rx_data        (rx_data),
        .busy           (busy),
        .done           (done),
        .lines_checked  (lines_checked),
        .error_cnt      (error_cnt),
        .first_err_valid(first_err_valid),
        .first_err_idx  (first_err_idx)
`ifdef TEST_DATA_VERIFY_MISMATCH_MASK_EN
        ,
        .first_err_mask (first_err_mask)
`endif
    );

    function automatic logic [63:0] rot(input logic [63:0] v, input int r);
        int s;
        s = r % 64;
        if (s == 0) return v;
        return (v << s) | (v >> (64 - s));
    endfunction

    // Closed form: line n word k = rotl(w0, 8n) ^ XOR_{j<n} rotl(rotl(seed,k), 8j)
    function automatic logic [DW-1:0] model_line(input logic [63:0] sd, input int n);
        logic [DW-1:0] l;
        logic [63:0]   s;
        logic [63:0]   w;
        for (int k = 0; k < WORDS; k++) begin
            s = rot(sd, k);
            w = rot(INIT_W[k % 8] ^ s, 8 * n);
            for (int j = 0; j < n; j++) w = w ^ rot(s, 8 * j);
            l[k*64 +: 64] = w;
        end
        return l;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour, advanced on every rising edge from the inputs seen there.
    logic             m_run = 1'b0, m_done = 1'b0, m_fev = 1'b0;
    logic [CW-1:0]    m_n = '0, m_cnt = '0, m_err = '0, m_fidx = '0;
    logic [63:0]      m_seed = '0;
    logic [WORDS-1:0] m_mask = '0;

    initial begin
        logic [DW-1:0]    exp_l;
        logic [WORDS-1:0] dm;
        forever begin
            @(posedge clk);
            if (!reset_n) begin
                m_run = 0; m_done = 0; m_fev = 0; m_n = '0; m_cnt = '0;
                m_err = '0; m_fidx = '0; m_seed = '0; m_mask = '0;
            end else if (m_run) begin
                if (m_cnt == m_n) begin
                    m_run  = 0;
                    m_done = 1;
                end else if (rx_valid) begin
                    exp_l = model_line(m_seed, int'(m_cnt));
                    for (int k = 0; k < WORDS; k++) dm[k] = exp_l[k*64 +: 64] != rx_data[k*64 +: 64];
                    if (dm != '0) begin
                        if (m_err != '1) m_err = m_err + 1;
                        if (!m_fev) begin
                            m_fev  = 1;
                            m_fidx = m_cnt;
                            m_mask = dm;
                        end
                    end
                    m_cnt = m_cnt + 1;
                end
            end else if (start) begin
                m_seed = seed; m_n = num_lines; m_cnt = '0; m_err = '0;
                m_fev = 0; m_fidx = '0; m_mask = '0; m_run = 1; m_done = 0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check("rx_ready", rx_ready, m_run && (m_cnt < m_n));
            check("busy", busy, m_run);
            check("done", done, m_done);
            check("lines_checked", lines_checked, m_cnt);
            check("error_cnt", error_cnt, m_err);
            check("first_err_valid", first_err_valid, m_fev);
            check("first_err_idx", first_err_idx, m_fidx);
`ifdef TEST_DATA_VERIFY_MISMATCH_MASK_EN
            check("first_err_mask", first_err_mask, m_mask);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [63:0] sd, input int n);
        seed = sd;
        num_lines = n;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [63:0] sd, input int n, input int bad_line,
                        input int bad_word, input bit gaps);
        int i = 0;
        int guard = 0;
        while (i < n && guard < 2000) begin
            guard++;
            if (gaps && $urandom_range(0, 2) == 0) begin
                rx_valid  = 1'b0;
                seed      = ~sd;
                num_lines = 1;
                start     = 1'b1;
                tick();
                start = 1'b0;
            end else begin
                rx_valid = 1'b1;
                rx_data  = model_line(sd, i);
                if (i == bad_line) rx_data[bad_word*64] = ~rx_data[bad_word*64];
                if (rx_ready) i++;
                tick();
            end
        end
        rx_valid = 1'b0;
        check("send_accepts", i, n);
    endtask

    task automatic wait_done(input int limit);
        int c = 0;
        while (!done && c < limit) begin
            tick();
            c++;
        end
        check("done_within_bound", done, 1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rx_ready"}, rx_ready, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_lines"}, lines_checked, 0);
        check({tag, "_errs"}, error_cnt, 0);
        check({tag, "_fev"}, first_err_valid, 0);
        check({tag, "_fidx"}, first_err_idx, 0);
    endtask

    initial begin
        logic [DW-1:0] l;
        int acc;

        reset_n = 1'b0;
        repeat (3) tick();
        check_reset_values("reset");
        reset_n = 1'b1;
        tick();

        // Pin the model against hand-computed words
        l = model_line(64'h0, 0);
        check("pin_s0_l0_w0", l[63:0], 64'h860761722b164a00);
        l = model_line(64'h0, 1);
        check("pin_s0_l1_w0", l[63:0], 64'h0761722b164a0086);
        l = model_line(64'h1, 0);
        check("pin_s1_l0_w1", l[127:64], 64'h54de0dc97b564cbd);
        l = model_line(64'h1, 1);
        check("pin_s1_l1_w0", l[63:0], 64'h0761722b164a0187);

        // Clean back-to-back run; done exactly one cycle after the last update
        do_start(64'h0, 4);
        check("t1_busy", busy, 1);
        send(64'h0, 4, -1, 0, 1'b0);
        check("t1_lines", lines_checked, 4);
        check("t1_not_done_yet", done, 0);
        tick();
        check("t1_done", done, 1);
        check("t1_busy_low", busy, 0);
        check("t1_errs", error_cnt, 0);
        check("t1_fev", first_err_valid, 0);

        // Single bit flip in line 5 word 2
        do_start(64'h1234, 8);
        send(64'h1234, 8, 5, 2, 1'b0);
        wait_done(5);
        check("t2_errs", error_cnt, 1);
        check("t2_fidx", first_err_idx, 5);
        check("t2_fev", first_err_valid, 1);
        check("t2_lines", lines_checked, 8);
`ifdef TEST_DATA_VERIFY_MISMATCH_MASK_EN
        check("t2_mask", first_err_mask, 64'h04);
`endif

        // rx_valid held for 6 cycles against a 3-line run
        do_start(64'h7, 3);
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            rx_valid = 1'b1;
            rx_data  = model_line(64'h7, acc);
            if (rx_ready) acc++;
            tick();
        end
        rx_valid = 1'b0;
        check("t3_accepts", acc, 3);
        check("t3_ready_low", rx_ready, 0);
        check("t3_lines", lines_checked, 3);
        check("t3_done", done, 1);

        // Zero-length run
        do_start(64'h5, 0);
        check("t4_busy", busy, 1);
        check("t4_no_ready", rx_ready, 0);
        check("t4_not_done", done, 0);
        tick();
        check("t4_done", done, 1);
        check("t4_busy_low", busy, 0);

        // Reset while line 2 of 10 is offered (an error already recorded on line 1)
        do_start(64'd99, 10);
        send(64'd99, 2, 1, 0, 1'b0);
        check("t5_err_before_reset", error_cnt, 1);
        rx_valid = 1'b1;
        rx_data  = model_line(64'd99, 2);
        reset_n  = 1'b0;
        tick();
        rx_valid = 1'b0;
        check_reset_values("t5_reset");
        reset_n = 1'b1;
        tick();
        check("t5_idle_no_ready", rx_ready, 0);
        do_start(64'd99, 10);
        send(64'd99, 10, -1, 0, 1'b0);
        wait_done(5);
        check("t5_lines", lines_checked, 10);
        check("t5_errs", error_cnt, 0);

        // Gaps plus ignored start pulses, then the same run without gaps
        for (int pass = 0; pass < 2; pass++) begin
            do_start(64'hABCD, 12);
            send(64'hABCD, 12, 3, 7, pass == 0);
            wait_done(5);
            check("t6_lines", lines_checked, 12);
            check("t6_errs", error_cnt, 1);
            check("t6_fidx", first_err_idx, 3);
`ifdef TEST_DATA_VERIFY_MISMATCH_MASK_EN
            check("t6_mask", first_err_mask, 64'h80);
`endif
        end

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
